mips_run_controller: RTL and testbench
======================================

MIPS_RUN_CONTROLLER -- requirements
Module: mips_run_controller

Interface
REQ-001 Parameter: IMEM_DEPTH, 256, instruction-memory depth in words (power of two).
REQ-002 Parameter: HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops execution.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  in  1  reset, synchronous and active-low.
REQ-005 Ports: load_valid in 1, load_ready out 1, load_data in 32, load_last in 1  host program-load stream.
REQ-006 Ports: start in 1 (run request); cycle_budget in 16 (max enabled CPU cycles per run).
REQ-007 Ports: imem_we out 1, imem_addr out log2(IMEM_DEPTH), imem_wdata out 32  instruction-memory write port.
REQ-008 Ports: cpu_en out 1 (processor clock-enable); cpu_instr in 32 (instruction fetched this cycle).
REQ-009 Ports: rf_raddr out 5, rf_rdata in 32  register-file combinational read port.
REQ-010 Ports: dump_valid out 1, dump_ready in 1, dump_data out 32, dump_last out 1  register dump stream.
REQ-011 Ports: busy out 1, done out 1, halt_cause out 2, cycles_run out 16, load_overflow out 1  status.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DUMP.
REQ-013 In IDLE: load_ready = !start && !load_overflow; each load_valid&&load_ready beat SHALL assert imem_we that cycle, with imem_wdata=load_data and imem_addr=load pointer.
REQ-014 The load pointer SHALL increment per accepted beat and clear to 0 after a beat with load_last=1.
REQ-015 A beat accepted at address IMEM_DEPTH-1 without load_last SHALL set load_overflow; further beats are refused until reset or start.
REQ-016 start in IDLE SHALL move to RUN next cycle, clear cycles_run, halt_cause, load_overflow and the load pointer; start wins over a simultaneous load beat, which is not accepted.
REQ-017 In RUN: cpu_en = (cpu_instr != HALT_WORD) (combinational), so the halt word is never executed.
REQ-018 cycles_run SHALL increment on every cycle with cpu_en=1 and saturate at 16'hFFFF.
REQ-019 cpu_instr==HALT_WORD in RUN SHALL set halt_cause=2'b01 and move to DUMP next cycle.
REQ-020 An enabled cycle with cycles_run==cycle_budget-1 SHALL set halt_cause=2'b10 and move to DUMP next cycle.
REQ-021 If halt word and budget expiry coincide, halt word wins (cpu_en=0, so the budget is not consumed).
REQ-022 cycle_budget=0 SHALL make RUN last one cycle with cpu_en=0, halt_cause=2'b10, then DUMP.
REQ-023 start, load_valid outside IDLE SHALL be ignored; load_ready=0; cpu_en=0 outside RUN.
REQ-024 In DUMP: rf_raddr=dump index, dump_data=rf_rdata, dump_valid=1; the index increments on dump_valid&&dump_ready.
REQ-025 dump_last=1 when index==31; the handshake on it SHALL return to IDLE and pulse done for exactly one cycle.
REQ-026 dump_data and rf_raddr SHALL stay stable while dump_valid&&!dump_ready.
REQ-027 busy=1 in RUN and DUMP; halt_cause and cycles_run hold until the next start.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force IDLE from any state, including mid-load, mid-run or mid-dump.
REQ-029 Reset values: load pointer 0, dump index 0, cycles_run 0, halt_cause 0, load_overflow 0, done 0, busy 0, cpu_en 0, imem_we 0, dump_valid 0.
REQ-030 Instruction-memory contents are not cleared by reset.

Structure
REQ-031 Shared package mips_ctrl_pkg SHALL hold the state enumeration, halt_cause codes (NONE=00, HALT_WORD=01, BUDGET=10) and the HALT_WORD default.
REQ-032 One sub-module, run_budget_counter, SHALL own cycles_run, saturation and budget-expiry detection.
REQ-033 The controller SHALL wrap an unmodified single_cycle_mips instance, acting only through cpu_en and the memory/register ports.

Verification
REQ-034 Load 4 words (last on 4th), start, budget 100, word 4 = HALT_WORD -> imem addr 0..3 written; halt_cause=01; cycles_run=3; 32 dump beats.
REQ-035 Program of infinite loop, budget 10 -> cpu_en high exactly 10 cycles; halt_cause=10; cycles_run=10.
REQ-036 Budget 0 -> no enabled cycle; DUMP entered 2 cycles after start; halt_cause=10.
REQ-037 dump_ready toggled 1/0 every cycle -> 32 beats, data stable while stalled, dump_last only on beat 31, done one cycle.
REQ-038 256 beats without load_last -> load_overflow=1; beat 257 refused; start clears load_overflow.
REQ-039 reset_n low for one cycle mid-DUMP at index 12 -> IDLE next cycle, dump_valid=0, next run's dump starts at index 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller: FSM states,
// halt-cause codes and the default halt instruction encoding.
package mips_ctrl_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CYCLE_W = 16;
    localparam int unsigned RF_AW   = 5;

    localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [RF_AW-1:0]  RF_LAST_IDX       = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_HALT_WORD = 2'b01,
        CAUSE_BUDGET    = 2'b10
    } halt_cause_e;

endpackage

// File: rtl/run_budget_counter.sv
// Counts enabled CPU cycles for the current run (saturating) and flags the
// cycle on which the run budget is used up.
module run_budget_counter
    import mips_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [CYCLE_W-1:0] budget_i,
    output logic [CYCLE_W-1:0] cycles_o,
    output logic               budget_zero_c_o,
    output logic               expire_c_o
);

    localparam logic [CYCLE_W-1:0] CYCLES_MAX = '1;

    logic [CYCLE_W-1:0] cycles_q;
    logic [CYCLE_W-1:0] cycles_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        cycles_d = cycles_q;
        if (clear_i) begin
            cycles_d = '0;
        end else if (en_i && (cycles_q != CYCLES_MAX)) begin
            cycles_d = cycles_q + CYCLE_W'(1);
        end
    end

    // >= rather than == so a budget lowered mid-run still stops the run
    assign budget_zero_c_o = (budget_i == '0);
    assign expire_c_o      = budget_zero_c_o || (cycles_q >= (budget_i - CYCLE_W'(1)));
    assign cycles_o        = cycles_q;

endmodule

// File: rtl/mips_run_controller.sv
// Host-facing run controller for a single-cycle MIPS core: loads the program
// into instruction memory, runs the core under a cycle budget, then streams out the register file.
module mips_run_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned       IMEM_DEPTH = 256,
    parameter logic [WORD_W-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [WORD_W-1:0]             load_data,
    input  logic                          load_last,
    input  logic                          start,
    input  logic [CYCLE_W-1:0]            cycle_budget,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [WORD_W-1:0]             imem_wdata,
    output logic                          cpu_en,
    input  logic [WORD_W-1:0]             cpu_instr,
    output logic [RF_AW-1:0]              rf_raddr,
    input  logic [WORD_W-1:0]             rf_rdata,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [WORD_W-1:0]             dump_data,
    output logic                          dump_last,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    halt_cause,
    output logic [CYCLE_W-1:0]            cycles_run,
    output logic                          load_overflow
);

    localparam int unsigned          IMEM_AW   = $clog2(IMEM_DEPTH);
    localparam logic [IMEM_AW-1:0]   IMEM_LAST = IMEM_AW'(IMEM_DEPTH - 1);

    ctrl_state_e        state_q,      state_d;
    halt_cause_e        halt_cause_q, halt_cause_d;
    logic [IMEM_AW-1:0] load_ptr_q,   load_ptr_d;
    logic [RF_AW-1:0]   dump_idx_q,   dump_idx_d;
    logic               overflow_q,   overflow_d;
    logic               done_q,       done_d;

    logic               run_clear;
    logic               budget_zero;
    logic               budget_expire;
    logic               is_halt;

    assign is_halt = (cpu_instr == HALT_WORD);

    run_budget_counter u_budget (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear_i         (run_clear),
        .en_i            (cpu_en),
        .budget_i        (cycle_budget),
        .cycles_o        (cycles_run),
        .budget_zero_c_o (budget_zero),
        .expire_c_o      (budget_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            halt_cause_q <= CAUSE_NONE;
            load_ptr_q   <= '0;
            dump_idx_q   <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            load_ptr_q   <= load_ptr_d;
            dump_idx_q   <= dump_idx_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        load_ptr_d   = load_ptr_q;
        dump_idx_d   = dump_idx_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        run_clear    = 1'b0;
        load_ready   = 1'b0;
        imem_we      = 1'b0;
        cpu_en       = 1'b0;
        dump_valid   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // start takes priority: a beat presented with it is refused
                load_ready = !start && !overflow_q;
                imem_we    = load_valid && load_ready;
                if (start) begin
                    state_d      = ST_RUN;
                    halt_cause_d = CAUSE_NONE;
                    load_ptr_d   = '0;
                    dump_idx_d   = '0;
                    overflow_d   = 1'b0;
                    run_clear    = 1'b1;
                end else if (imem_we) begin
                    if (load_last) begin
                        load_ptr_d = '0;
                    end else begin
                        load_ptr_d = load_ptr_q + IMEM_AW'(1);
                        if (load_ptr_q == IMEM_LAST) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end

            ST_RUN: begin
                // halt word is checked first so it is never executed nor charged to the budget
                cpu_en = !is_halt && !budget_zero;
                if (is_halt) begin
                    halt_cause_d = CAUSE_HALT_WORD;
                    state_d      = ST_DUMP;
                end else if (budget_expire) begin
                    halt_cause_d = CAUSE_BUDGET;
                    state_d      = ST_DUMP;
                end
            end

            ST_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    dump_idx_d = dump_idx_q + RF_AW'(1);
                    if (dump_idx_q == RF_LAST_IDX) begin
                        dump_idx_d = '0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr     = load_ptr_q;
    assign imem_wdata    = load_data;
    assign rf_raddr      = dump_idx_q;
    assign dump_data     = rf_rdata;
    assign dump_last     = (state_q == ST_DUMP) && (dump_idx_q == RF_LAST_IDX);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign halt_cause    = halt_cause_q;
    assign load_overflow = overflow_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller: stand-in CPU and register file, directed and
// randomized programs checked against a rule-level outcome model.
module tb_mips_run_controller;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] LOOP = 32'h1000_FFFF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_valid, load_ready, load_last, start;
    logic [31:0] load_data;
    logic [15:0] cycle_budget;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_en;
    logic [31:0] cpu_instr;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid, dump_ready, dump_last;
    logic [31:0] dump_data;
    logic        busy, done, load_overflow;
    logic [1:0]  halt_cause;
    logic [15:0] cycles_run;

    int checks   = 0;
    int failures = 0;

    logic [31:0] imem [256];
    logic [31:0] rf   [32];
    logic [7:0]  pc;
    logic [31:0] prog [$];

    always #5 clock = ~clock;

    mips_run_controller dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .start         (start),
        .cycle_budget  (cycle_budget),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_en        (cpu_en),
        .cpu_instr     (cpu_instr),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_data     (dump_data),
        .dump_last     (dump_last),
        .busy          (busy),
        .done          (done),
        .halt_cause    (halt_cause),
        .cycles_run    (cycles_run),
        .load_overflow (load_overflow)
    );

    // Stand-in core: fetches imem[pc]; LOOP branches to itself, anything else falls through.
    always @(posedge clock) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
    end

    always @(posedge clock) begin
        if (!busy)                             pc <= 8'd0;
        else if (cpu_en && (imem[pc] != LOOP)) pc <= pc + 8'd1;
    end

    assign cpu_instr = imem[pc];
    assign rf_rdata  = rf[rf_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input string tag, input bit with_last);
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clock);
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = with_last && (i == prog.size() - 1);
            #1;
            check($sformatf("%s_we[%0d]", tag, i), 32'(imem_we), 32'd1);
            check($sformatf("%s_addr[%0d]", tag, i), 32'(imem_addr), 32'(i));
        end
        @(negedge clock);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic kick(input string tag, input int budget);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        @(negedge clock);
        start        = 1'b1;
        cycle_budget = 16'(budget);
        load_valid   = 1'b1;
        load_data    = 32'hDEAD_0000;
        #1;
        check({tag, "_start_ready"}, 32'(load_ready), 32'd0);
        check({tag, "_start_we"}, 32'(imem_we), 32'd0);
        @(negedge clock);
        start      = 1'b0;
        load_valid = 1'b0;
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ovf_clr"}, 32'(load_overflow), 32'd0);
        check({tag, "_cyc_clr"}, 32'(cycles_run), 32'd0);
        check({tag, "_cause_clr"}, 32'(halt_cause), 32'd0);
    endtask

    // Outcome of a program of n_pre ordinary words followed by HALT (or a self-loop if loops=1).
    task automatic run_and_check(input string tag, input int budget, input int n_pre,
                                 input bit loops, input int ready_mode);
        int          exp_cyc;
        logic [1:0]  exp_cause;
        int          en_cnt = 0, beats = 0, done_cnt = 0, post = 0;
        int          first_dump = -1, last_hs = -1, done_k = -1;
        bit          prev_stall = 1'b0, finished = 1'b0;
        logic [31:0] prev_data = '0;
        logic [4:0]  prev_raddr = '0;

        if (budget == 0) begin
            exp_cause = 2'b10; exp_cyc = 0;
        end else if (!loops && n_pre < budget) begin
            exp_cause = 2'b01; exp_cyc = n_pre;
        end else begin
            exp_cause = 2'b10; exp_cyc = budget;
        end

        kick(tag, budget);
        for (int k = 1; k <= 3000; k++) begin
            if (k > 1) @(negedge clock);
            case (ready_mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = (k % 2 == 1);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cpu_en) en_cnt++;
            if (dump_valid && first_dump < 0) first_dump = k;
            if (prev_stall) begin
                check($sformatf("%s_stall_data[%0d]", tag, beats), dump_data, prev_data);
                check($sformatf("%s_stall_addr[%0d]", tag, beats), 32'(rf_raddr), 32'(prev_raddr));
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
            prev_raddr = rf_raddr;
            if (dump_valid && dump_ready) begin
                check($sformatf("%s_raddr[%0d]", tag, beats), 32'(rf_raddr), 32'(beats));
                check($sformatf("%s_data[%0d]", tag, beats), dump_data, rf[beats]);
                check($sformatf("%s_last[%0d]", tag, beats), 32'(dump_last), 32'(beats == 31));
                beats++;
                last_hs = k;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (beats == 32 && !busy) begin
                post++;
                if (post == 3) begin
                    finished = 1'b1;
                    break;
                end
            end
        end
        dump_ready = 1'b0;
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(exp_cyc));
        check({tag, "_cycles_run"}, 32'(cycles_run), 32'(exp_cyc));
        check({tag, "_halt_cause"}, 32'(halt_cause), 32'(exp_cause));
        check({tag, "_beats"}, 32'(beats), 32'd32);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_time"}, 32'(done_k), 32'(last_hs + 1));
        if (budget == 0) check({tag, "_dump_at"}, 32'(first_dump), 32'd2);
    endtask

    initial begin
        int          n, b;
        logic [31:0] w;
        bit          hit;

        reset_n = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        start = 1'b0; cycle_budget = '0; dump_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_cause", 32'(halt_cause), 32'd0);
        check("rst_cycles", 32'(cycles_run), 32'd0);
        check("rst_ovf", 32'(load_overflow), 32'd0);
        check("rst_ptr", 32'(imem_addr), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        reset_n = 1'b1;

        prog = {32'd1, 32'd2, 32'd3, HALT};
        load_prog("basic_ld", 1'b1);
        run_and_check("basic", 100, 3, 1'b0, 0);

        prog = {LOOP};
        load_prog("loop_ld", 1'b1);
        run_and_check("loop", 10, 0, 1'b1, 0);

        prog = {32'd5, HALT};
        load_prog("b0_ld", 1'b1);
        run_and_check("budget0", 0, 1, 1'b0, 0);

        prog = {32'd7, 32'd8, HALT};
        load_prog("tog_ld", 1'b1);
        run_and_check("toggle", 20, 2, 1'b0, 1);

        prog = {32'd1, 32'd2, 32'd3, 32'd4, HALT};
        load_prog("coin_ld", 1'b1);
        run_and_check("coincide", 5, 4, 1'b0, 2);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 20));
            b = int'($urandom_range(0, 25));
            hit = (r % 2 == 1);
            prog = {};
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == HALT || w == LOOP) w = 32'd0;
                prog.push_back(w);
            end
            prog.push_back(hit ? LOOP : HALT);
            load_prog($sformatf("rnd%0d_ld", r), 1'b1);
            run_and_check($sformatf("rnd%0d", r), b, n, hit, 2);
        end

        prog = {};
        for (int i = 0; i < 256; i++) prog.push_back(32'(i));
        load_prog("ovf_ld", 1'b0);
        #1;
        check("ovf_set", 32'(load_overflow), 32'd1);
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = 32'h1234_5678;
        #1;
        check("ovf_refuse_ready", 32'(load_ready), 32'd0);
        check("ovf_refuse_we", 32'(imem_we), 32'd0);
        @(negedge clock);
        load_valid = 1'b0;
        run_and_check("ovf_run", 5, 256, 1'b0, 0);

        prog = {HALT};
        load_prog("ptr_clr_ld", 1'b1);
        run_and_check("halt_first", 3, 0, 1'b0, 0);

        prog = {32'd9, 32'd10, HALT};
        load_prog("rst_ld", 1'b1);
        kick("rstrun", 50);
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            dump_ready = 1'b1;
            #1;
            if (dump_valid && rf_raddr == 5'd12) begin
                hit = 1'b1;
                break;
            end
        end
        check("rstrun_reached12", 32'(hit), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n    = 1'b1;
        dump_ready = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dump_valid", 32'(dump_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cause", 32'(halt_cause), 32'd0);
        check("midrst_cycles", 32'(cycles_run), 32'd0);
        check("midrst_raddr", 32'(rf_raddr), 32'd0);
        run_and_check("after_rst", 50, 2, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
